// File: rtl/reg_bank_alloc_arbiter_if.sv
`default_nettype none
// ============================================================================
// reg_bank_alloc_arbiter_if : allocation, free, flush and status bundle
// Rev 1.0
// ============================================================================
interface reg_bank_alloc_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
);
   logic [N_REQ-1:0]  alloc_req;
   logic [N_REQ-1:0]  alloc_gnt;
   logic [ADDR_W-1:0] alloc_addr;
   logic              free_en;
   logic [ADDR_W-1:0] free_addr;
   logic              flush_req;
   logic              flush_done;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W:0]   occupancy;
   logic              full;
   logic              empty;
   logic              err_double_free;

   modport master (
      output alloc_req, free_en, free_addr, flush_req,
      input  alloc_gnt, alloc_addr, flush_done, clr_en, clr_addr,
             occupancy, full, empty, err_double_free
   );

   modport slave (
      input  alloc_req, free_en, free_addr, flush_req,
      output alloc_gnt, alloc_addr, flush_done, clr_en, clr_addr,
             occupancy, full, empty, err_double_free
   );
endinterface
`default_nettype wire

// File: rtl/reg_bank_alloc_arbiter.sv
`default_nettype none
// ============================================================================
// reg_bank_alloc_arbiter : round-robin register allocator with free bypass
//                          and sweeping flush for one register bank
// Rev 1.0
// ============================================================================
module reg_bank_alloc_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   reg_bank_alloc_arbiter_if.slave  bus
);
   localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t            r_state;
   logic [DEPTH-1:0]  r_valid;
   logic [RR_W-1:0]   r_rr_ptr;
   logic [ADDR_W:0]   r_occ;
   logic [ADDR_W-1:0] r_sweep;
   logic              r_clr_en;
   logic              r_flush_done;
   logic              r_err;

   logic              w_run_ok;
   logic              w_free_valid;
   logic              w_free_dbl;
   logic [DEPTH-1:0]  w_cand;
   logic [ADDR_W-1:0] w_alloc_addr;
   logic              w_any_free;
   logic [RR_W-1:0]   w_idx;
   logic [RR_W-1:0]   w_gnt_idx;
   logic              w_found;
   logic              w_grant;
   logic [N_REQ-1:0]  w_gnt;

   always_comb begin
      w_run_ok     = (r_state == RUN) && !bus.flush_req;
      w_free_valid = bus.free_en && w_run_ok && r_valid[bus.free_addr];
      w_free_dbl   = bus.free_en && w_run_ok && !r_valid[bus.free_addr];

      // A register released this cycle is immediately reusable.
      w_cand = ~r_valid;
      if (w_free_valid) begin
         w_cand[bus.free_addr] = 1'b1;
      end

      w_alloc_addr = '0;
      w_any_free   = 1'b0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
         if (w_cand[j]) begin
            w_alloc_addr = ADDR_W'(j);
            w_any_free   = 1'b1;
         end
      end

      w_idx     = '0;
      w_gnt_idx = '0;
      w_found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = RR_W'((int'(r_rr_ptr) + i) % N_REQ);
         if (!w_found && bus.alloc_req[w_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_idx;
         end
      end

      w_grant = w_run_ok && w_any_free && w_found;
      w_gnt   = '0;
      if (w_grant) begin
         w_gnt[w_gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RUN;
         r_valid      <= '0;
         r_rr_ptr     <= '0;
         r_occ        <= '0;
         r_sweep      <= '0;
         r_clr_en     <= 1'b0;
         r_flush_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            RUN: begin
               if (bus.flush_req) begin
                  r_state  <= FLUSH;
                  r_sweep  <= '0;
                  r_clr_en <= 1'b1;
               end else begin
                  if (w_free_dbl) begin
                     r_err <= 1'b1;
                  end
                  // Grant write follows the free so a same-address hit stays set.
                  if (w_free_valid) begin
                     r_valid[bus.free_addr] <= 1'b0;
                  end
                  if (w_grant) begin
                     r_valid[w_alloc_addr] <= 1'b1;
                     r_rr_ptr <= (w_gnt_idx == RR_W'(N_REQ - 1)) ? '0
                                                                   : w_gnt_idx + RR_W'(1);
                  end
                  case ({w_grant, w_free_valid})
                     2'b10:   r_occ <= r_occ + (ADDR_W+1)'(1);
                     2'b01:   r_occ <= r_occ - (ADDR_W+1)'(1);
                     default: r_occ <= r_occ;
                  endcase
               end
            end
            FLUSH: begin
               r_valid[r_sweep] <= 1'b0;
               r_sweep          <= r_sweep + ADDR_W'(1);
               if (r_sweep == ADDR_W'(DEPTH - 1)) begin
                  r_state      <= RUN;
                  r_occ        <= '0;
                  r_clr_en     <= 1'b0;
                  r_flush_done <= 1'b1;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign bus.alloc_gnt       = w_gnt;
   assign bus.alloc_addr      = w_alloc_addr;
   assign bus.clr_en          = r_clr_en;
   assign bus.clr_addr        = r_sweep;
   assign bus.flush_done      = r_flush_done;
   assign bus.occupancy       = r_occ;
   assign bus.full            = (r_occ == (ADDR_W+1)'(DEPTH));
   assign bus.empty           = (r_occ == '0);
   assign bus.err_double_free = r_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_alloc_arbiter.sv
`default_nettype none
// ============================================================================
// tb_reg_bank_alloc_arbiter : directed scoreboard bench for the allocator
// Rev 1.0
// ============================================================================
module tb_reg_bank_alloc_arbiter;
   localparam int N_REQ  = 4;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_bank_alloc_arbiter_if #(.N_REQ(N_REQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

   reg_bank_alloc_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [8:0]  gnt_q[$];   // {alloc_gnt, alloc_addr}
   logic [4:0]  clr_q[$];
   int          done_q[$];
   logic [3:0]  sampled_gnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs are driven just after a rising edge; grants are sampled mid-cycle.
   task automatic step(input logic [3:0] req, input logic fen, input logic [4:0] fa,
                       input logic fr);
      bus.alloc_req = req;
      bus.free_en   = fen;
      bus.free_addr = fa;
      bus.flush_req = fr;
      @(negedge clk);
      sampled_gnt = bus.alloc_gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(4'b0000, 1'b0, 5'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [8:0] e9;
      logic [4:0] e5;
      int         d;
      if (bus.alloc_gnt != 4'b0000) begin
         checks++;
         if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL grant: unexpected gnt=%b addr=%0d", bus.alloc_gnt, bus.alloc_addr);
         end else begin
            e9 = gnt_q.pop_front();
            if ({bus.alloc_gnt, bus.alloc_addr} !== e9) begin
               errors++;
               $display("FAIL grant: got gnt=%b addr=%0d expected gnt=%b addr=%0d",
                        bus.alloc_gnt, bus.alloc_addr, e9[8:5], e9[4:0]);
            end
         end
      end
      if (bus.clr_en) begin
         checks++;
         if (clr_q.size() == 0) begin
            errors++;
            $display("FAIL clear: unexpected clr_addr=%0d", bus.clr_addr);
         end else begin
            e5 = clr_q.pop_front();
            if (bus.clr_addr !== e5) begin
               errors++;
               $display("FAIL clear: got clr_addr=%0d expected %0d", bus.clr_addr, e5);
            end
         end
      end
      if (bus.flush_done) begin
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL flush_done: unexpected pulse got 1 expected 0");
         end else begin
            d = done_q.pop_front();
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.alloc_req = '0;
      bus.free_en   = 1'b0;
      bus.free_addr = '0;
      bus.flush_req = 1'b0;

      // Reset state
      do_reset();
      check("rst_occupancy", 32'(bus.occupancy), 0);
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_err", 32'(bus.err_double_free), 0);
      check("rst_clr_en", 32'(bus.clr_en), 0);
      check("rst_clr_addr", 32'(bus.clr_addr), 0);
      check("rst_flush_done", 32'(bus.flush_done), 0);

      // Single requester gets ascending addresses
      for (int k = 0; k < 3; k++) begin
         gnt_q.push_back({4'b0001, 5'(k)});
         step(4'b0001, 1'b0, 5'd0, 1'b0);
      end
      idle();
      check("single_occupancy", 32'(bus.occupancy), 3);

      // All requesters rotate round-robin
      do_reset();
      gnt_q.push_back({4'b0001, 5'd0});
      gnt_q.push_back({4'b0010, 5'd1});
      gnt_q.push_back({4'b0100, 5'd2});
      gnt_q.push_back({4'b1000, 5'd3});
      for (int k = 0; k < 4; k++) step(4'b1111, 1'b0, 5'd0, 1'b0);
      check("rr_occupancy", 32'(bus.occupancy), 4);

      // Fill the bank, then exercise full and bypass
      for (int k = 4; k < DEPTH; k++) begin
         gnt_q.push_back({4'b0001, 5'(k)});
         step(4'b0001, 1'b0, 5'd0, 1'b0);
      end
      check("fill_occupancy", 32'(bus.occupancy), 32);
      check("fill_full", 32'(bus.full), 1);
      check("fill_empty", 32'(bus.empty), 0);
      step(4'b0001, 1'b0, 5'd0, 1'b0);
      check("full_no_grant", 32'(sampled_gnt), 0);
      gnt_q.push_back({4'b0001, 5'd17});
      step(4'b0001, 1'b1, 5'd17, 1'b0);
      check("bypass_occupancy", 32'(bus.occupancy), 32);
      check("bypass_full", 32'(bus.full), 1);

      // Double free
      step(4'b0000, 1'b1, 5'd5, 1'b0);
      check("free_occupancy", 32'(bus.occupancy), 31);
      check("free_no_err", 32'(bus.err_double_free), 0);
      step(4'b0000, 1'b1, 5'd5, 1'b0);
      check("dbl_err", 32'(bus.err_double_free), 1);
      check("dbl_occupancy", 32'(bus.occupancy), 31);
      idle();
      idle();
      check("dbl_err_sticky", 32'(bus.err_double_free), 1);

      // Flush with occupancy 10
      do_reset();
      check("rst_err_cleared", 32'(bus.err_double_free), 0);
      for (int k = 0; k < 10; k++) begin
         gnt_q.push_back({4'b0001, 5'(k)});
         step(4'b0001, 1'b0, 5'd0, 1'b0);
      end
      check("pre_flush_occupancy", 32'(bus.occupancy), 10);
      for (int k = 0; k < DEPTH; k++) clr_q.push_back(5'(k));
      done_q.push_back(1);
      step(4'b0001, 1'b1, 5'd3, 1'b1);
      check("flush_req_no_grant", 32'(sampled_gnt), 0);
      check("flush_free_ignored", 32'(bus.occupancy), 10);
      step(4'b0001, 1'b1, 5'd20, 1'b0);
      for (int k = 1; k < DEPTH; k++) step(4'b0001, 1'b0, 5'd0, 1'b0);
      check("flush_done_pulse", 32'(bus.flush_done), 1);
      check("flush_occupancy", 32'(bus.occupancy), 0);
      check("flush_clr_off", 32'(bus.clr_en), 0);
      check("flush_no_err", 32'(bus.err_double_free), 0);
      gnt_q.push_back({4'b0001, 5'd0});
      step(4'b0001, 1'b0, 5'd0, 1'b0);
      check("flush_done_single", 32'(bus.flush_done), 0);
      check("post_flush_occupancy", 32'(bus.occupancy), 1);
      idle();

      // Reset in the middle of a flush at sweep 12
      do_reset();
      for (int k = 0; k <= 12; k++) clr_q.push_back(5'(k));
      step(4'b0000, 1'b0, 5'd0, 1'b1);
      for (int k = 0; k < 12; k++) idle();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      check("midrst_clr_en", 32'(bus.clr_en), 0);
      check("midrst_flush_done", 32'(bus.flush_done), 0);
      check("midrst_clr_addr", 32'(bus.clr_addr), 0);
      for (int k = 0; k < 40; k++) idle();
      gnt_q.push_back({4'b0001, 5'd0});
      step(4'b0001, 1'b0, 5'd0, 1'b0);
      idle();

      check("grant_queue_drained", 32'(gnt_q.size()), 0);
      check("clear_queue_drained", 32'(clr_q.size()), 0);
      check("done_queue_drained", 32'(done_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
